if_id_skid_reg: RTL
===================

// Module: if_id_skid_reg
// PURPOSE
//   IF->ID pipeline boundary for the pipelined MIPS core. Captures {pc, instr} from the
//   fetch stage (PC register + instruction memory) and presents it to decode.
//   Two-entry skid buffer with valid/ready handshakes so that in_ready is registered,
//   decode backpressure never loses an instruction, and a flush squashes everything held.
// PARAMETERS
//   PC_W     32             PC width in bits
//   INSTR_W  32             instruction width in bits
//   NOP      32'h0000_0000  instr value driven while out_valid=0 (sll $0,$0,0)
// PORTS
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous reset, active-low
//   flush      in   1        squash all held entries (branch/jump redirect)
//   in_valid   in   1        fetch presents an instruction
//   in_ready   out  1        buffer can accept this cycle
//   in_pc      in   PC_W     PC of the fetched instruction
//   in_instr   in   INSTR_W  fetched instruction word
//   out_valid  out  1        decode-side entry valid
//   out_ready  in   1        decode consumes this cycle
//   out_pc     out  PC_W     PC of presented instruction
//   out_pc4    out  PC_W     out_pc + 4, computed at capture, wraps modulo 2^PC_W
//   out_instr  out  INSTR_W  presented instruction; NOP when out_valid=0
// BEHAVIOUR
//   - Reset (reset_n=0, async): state EMPTY, out_valid=0, out_pc=0, out_pc4=0,
//     out_instr=NOP, in_ready=0 while reset_n=0; in_ready=1 from the first edge after release.
//   - Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//   - in_ready = (state != FULL), derived only from registered state; no in->out comb path.
//   - Latency: accepted instr appears on out_* the cycle after acceptance (1 cycle).
//   - States: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
//     EMPTY: in_xfer -> ONE, main <= in.
//     ONE:   in_xfer & out_xfer -> ONE, main <= in; in_xfer & !out_ready -> FULL, skid <= in;
//            !in_xfer & out_xfer -> EMPTY; else hold.
//     FULL:  out_xfer -> ONE, main <= skid (order preserved); else hold. No input accepted.
//   - flush (synchronous, highest priority): next state EMPTY, both entries invalid.
//     An in_xfer in the flush cycle is dropped; out_xfer in that cycle still completes.
//   - out_* held stable while out_valid & !out_ready (no data change under stall).
//   - out_pc4 wrap: in_pc = 32'hFFFF_FFFC -> out_pc4 = 32'h0000_0000.
//   - Reset asserted mid-operation discards all entries immediately (async).
// CONFIGURATION
//   Macro IF_ID_PERF_EN:
//     defined   -> extra output stall_cnt [15:0]: increments each cycle out_valid & !out_ready,
//                  saturates at 16'hFFFF, cleared by reset_n only (not by flush).
//     undefined -> port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package mips_pipe_pkg: typedef enum logic [1:0] {EMPTY, ONE, FULL} ifid_state_t;
//     typedef struct packed {pc, pc4, instr} ifid_t; localparam NOP_INSTR.
//   Sub-module if_id_entry: one storage slot (valid + ifid_t) with load/clear; instantiated
//     twice (main, skid). Top holds state FSM, in_ready, mux main<-in/skid, optional counter.
// TESTING
//   1 Reset: reset_n=0 mid-clock -> out_valid=0, out_instr=NOP immediately; in_ready=1 after release.
//   2 Stream: in_valid=1, out_ready=1, pc 0x0,0x4,0x8 -> out_pc same order, 1-cycle lag, pc4 0x4,0x8,0xC.
//   3 Backpressure: out_ready=0 with 3 offered (0x8C01_0000, 0x0022_1820, 0xAC03_0004) ->
//     first two held (FULL, in_ready=0), third stalled; out_ready=1 -> delivered in order, none lost.
//   4 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_instr=NOP, in_ready=1, no old data.
//   5 Wrap: in_pc=32'hFFFF_FFFC -> out_pc4=32'h0000_0000.
//   6 IF_ID_PERF_EN: out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; flush leaves it 5.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline boundary registers.
// ifid_t is sized by IFID_PC_W / IFID_INSTR_W; the IF->ID register
// parameters must match these widths.
package mips_pipe_pkg;

    localparam int          IFID_PC_W    = 32;
    localparam int          IFID_INSTR_W = 32;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_t;

    typedef struct packed {
        logic [IFID_PC_W-1:0]    pc;
        logic [IFID_PC_W-1:0]    pc4;
        logic [IFID_INSTR_W-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/if_id_entry.sv
// One storage slot of the IF->ID skid buffer: a valid bit plus payload.
// clr has priority over load; payload is left untouched on clear.
module if_id_entry #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot register: valid tracks occupancy, data captured on load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register built as a two-entry skid buffer (main + skid).
// in_ready is a flop, so fetch never sees a combinational path from decode.
// Optional feature: define IF_ID_PERF_EN to add the stall_cnt output.
module if_id_skid_reg
    import mips_pipe_pkg::*;
#(
    parameter int                 PC_W    = IFID_PC_W,
    parameter int                 INSTR_W = IFID_INSTR_W,
    parameter logic [INSTR_W-1:0] NOP     = NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc4,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    ifid_state_t state_q, state_d;
    logic        in_ready_q;
    logic        in_xfer, out_xfer;
    logic        main_load, main_clr, skid_load, skid_clr;
    logic        main_vld, skid_vld;
    ifid_t       cap, main_d, main_q, skid_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    // Capture the fetched word; pc4 is computed here so decode gets it registered.
    always_comb begin
        cap       = '0;
        cap.pc    = in_pc;
        cap.pc4   = in_pc + PC_W'(4);
        cap.instr = in_instr;
    end

    // Main slot refills from skid when draining FULL, otherwise from fetch.
    always_comb begin
        main_d = skid_vld ? skid_q : cap;
    end

    // Occupancy state and registered in_ready (held low throughout reset).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Next state and slot controls; flush overrides every transfer.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    if_id_entry #(.W($bits(ifid_t))) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (main_clr),
        .load_i  (main_load),
        .d_i     (main_d),
        .valid_o (main_vld),
        .q_o     (main_q)
    );

    if_id_entry #(.W($bits(ifid_t))) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (skid_clr),
        .load_i  (skid_load),
        .d_i     (cap),
        .valid_o (skid_vld),
        .q_o     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_pc    = main_q.pc;
    assign out_pc4   = main_q.pc4;
    assign out_instr = main_vld ? main_q.instr : NOP;

`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of decode stall cycles; only reset clears it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
